// File: rtl/reg_bank_param.sv
// reg_bank_param: parametrised complex register bank, dual registered read with write-through bypass and sequenced bulk clear
// Ports:
//   i_clock, i_reset_n      : clock (posedge), async active-low reset
//   i_regwen/i_selwreg/i_inA/i_endwreg : write port; mode 00 both, 10 real, 01 imag, 11 swap halves
//   i_seloutX/i_cnstX/i_enrregX : read port X (A/B); register or constant (index mod 9) source
//   i_clr_req               : start bulk clear when idle
//   o_outX/o_validX         : registered read data and one-cycle update pulse
//   o_busy                  : bulk clear in progress
module reg_bank_param #(
  parameter int HALF_W = 32,
  parameter int NREGS = 16,
  parameter int AW = 4,
  localparam int DATA_W = 2 * HALF_W
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_regwen,
  input  logic [DATA_W-1:0] i_inA,
  input  logic [AW-1:0]     i_selwreg,
  input  logic [1:0]        i_endwreg,
  input  logic [AW-1:0]     i_seloutA,
  input  logic [AW-1:0]     i_seloutB,
  input  logic              i_cnstA,
  input  logic              i_cnstB,
  input  logic              i_enrregA,
  input  logic              i_enrregB,
  input  logic              i_clr_req,
  output logic [DATA_W-1:0] o_outA,
  output logic [DATA_W-1:0] o_outB,
  output logic              o_validA,
  output logic              o_validB,
  output logic              o_busy
);
  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [AW-1:0] r_cnt;
  logic [DATA_W-1:0] r_outA, r_outB, w_old, w_merged, w_srcA, w_srcB;
  logic [HALF_W-1:0] w_re, w_im;
  logic r_validA, r_validB, w_idle, w_wr;
  // Constant table is a 3x3 grid: real from index mod 3, imag from index div 3, each cycling +1, 0, -1
  function automatic logic [DATA_W-1:0] cnst(input logic [AW-1:0] s);
    logic [31:0] k, kr, ki;
    logic [HALF_W-1:0] re, im;
    k = 32'(s) % 32'd9;
    kr = k % 32'd3;
    ki = k / 32'd3;
    re = (kr == 32'd0) ? HALF_W'(1) : (kr == 32'd1) ? '0 : '1;
    im = (ki == 32'd0) ? HALF_W'(1) : (ki == 32'd1) ? '0 : '1;
    return {re, im};
  endfunction
  assign w_idle = (r_state == S_IDLE);
  // A simultaneous clear request takes priority, so the write is dropped
  assign w_wr = w_idle & i_regwen & ~i_clr_req;
  assign w_old = r_regs[i_selwreg];
  assign w_re = i_inA[DATA_W-1:HALF_W];
  assign w_im = i_inA[HALF_W-1:0];
  assign w_merged = (i_endwreg == 2'b00) ? {w_re, w_im} :
                    (i_endwreg == 2'b10) ? {w_re, w_old[HALF_W-1:0]} :
                    (i_endwreg == 2'b01) ? {w_old[DATA_W-1:HALF_W], w_im} : {w_im, w_re};
  assign w_srcA = i_cnstA ? cnst(i_seloutA) : (w_wr && i_selwreg == i_seloutA) ? w_merged : r_regs[i_seloutA];
  assign w_srcB = i_cnstB ? cnst(i_seloutB) : (w_wr && i_selwreg == i_seloutB) ? w_merged : r_regs[i_seloutB];
  always_comb begin
    w_next = r_state;
    if (w_idle && i_clr_req) w_next = S_CLEAR;
    else if (!w_idle && r_cnt == AW'(NREGS - 1)) w_next = S_IDLE;
  end
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_cnt <= '0;
      r_outA <= '0;
      r_outB <= '0;
      r_validA <= 1'b0;
      r_validB <= 1'b0;
    end else begin
      r_validA <= w_idle & i_enrregA;
      r_validB <= w_idle & i_enrregB;
      if (w_idle && i_enrregA) r_outA <= w_srcA;
      if (w_idle && i_enrregB) r_outB <= w_srcB;
      if (w_wr) r_regs[i_selwreg] <= w_merged;
      if (!w_idle) begin
        r_regs[r_cnt] <= '0;
        r_cnt <= r_cnt + AW'(1);
      end else if (i_clr_req) r_cnt <= '0;
    end
  end
  assign o_outA = r_outA;
  assign o_outB = r_outB;
  assign o_validA = r_validA;
  assign o_validB = r_validB;
  assign o_busy = !w_idle;
endmodule
